// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: done XLEN+2 cycles after acceptance; divide-by-zero / signed overflow finish in 1 cycle.
// Backpressure: start sampled only in IDLE, busy stalls the pipeline, no queueing; flush aborts.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [XLEN-1:0]   opnd_q;      // multiplicand magnitude, or divisor magnitude
    logic [2*XLEN-1:0] acc_q;       // {hi, lo} product, or {rem, quot}
    logic [CW-1:0]     count_q;

    // Operand decode at acceptance: signedness, magnitudes, special divide cases
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    assign is_div      = funct3[2];
    assign a_signed    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    assign b_signed    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign neg_a       = a_signed & op_a[XLEN-1];
    assign neg_b       = b_signed & op_b[XLEN-1];
    assign mag_a       = neg_a ? -op_a : op_a;
    assign mag_b       = neg_b ? -op_b : op_b;
    assign div_zero    = is_div && (op_b == '0);
    assign div_ovf     = is_div && !funct3[0] && (op_a == INT_MIN) && (op_b == ALL_ONES);
    // Divide by zero: quotient all-ones, remainder = dividend.
    // Signed overflow: quotient = dividend, remainder = 0.
    assign special_res = div_zero ? (funct3[1] ? op_a : ALL_ONES)
                                  : (funct3[1] ? '0   : op_a);

    // One iteration of shift-add multiply: add multiplicand to upper half if LSB set, shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // One iteration of restoring divide: shift {rem, quot} left, trial-subtract divisor
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ge   = div_sh >= {1'b0, opnd_q};
    assign div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

    // Sign correction of the unsigned core result
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quot_fix) : mul_res;

    // Control FSM with registered busy/done/result and the iterative datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            count_q  <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= funct3;
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
                        count_q  <= CNT_INIT;
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            opnd_q <= is_div ? mag_b : mag_a;
                            acc_q  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                            busy   <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q   <= op_q[2] ? div_next : mul_next;
                    count_q <= count_q - CNT_LAST;
                    if (count_q == CNT_LAST) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    result <= fix_res;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M/RV64M multiply/divide execution unit for the RISC-V core, the sequential companion of the ALU decoder. The unit accepts an M-extension operation (funct3 with funct7 = 0000001) and two XLEN-bit register operands, and computes the result over multiple cycles using radix-2 shift-add multiplication or restoring division. It sits in the execute stage beside the single-cycle ALU. While the unit is busy, the hazard unit stalls the pipeline.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 operand (multiplicand / dividend).
- op_b  in  XLEN  rs2 operand (multiplier / divisor).
- flush  in  1  abort in-flight op (branch mispredict / trap).
- busy  out  1  high from the cycle after acceptance until the cycle done is high, inclusive of neither.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  registered result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: start=1 accepts the request. The unit latches funct3, the operand magnitudes, the sign flags, and a counter = XLEN.
  - Special cases go directly to DONE.
  - Otherwise the unit goes to CALC.
- Signedness per operand:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MUL, MULHU, DIVU, REMU: both operands unsigned. MUL low bits are sign-agnostic.
- CALC, multiply: the unit holds a 2*XLEN-bit product register. Each cycle, if the multiplier LSB is 1, the unit adds the multiplicand into the upper half, then shifts right by 1.
- CALC, divide: each cycle the unit shifts {rem, quot} left by 1 and trial-subtracts the divisor. If the difference is non-negative it keeps the difference and sets quot LSB to 1.
- CALC: the counter decrements each cycle. When the counter reaches 1, the next state is FIXUP.
- FIXUP, multiply: if the sign flags differ, the unit negates the 2*XLEN product. It selects the low half for MUL and the high half otherwise.
- FIXUP, divide: quotient is negated if the signs differ. Remainder takes the sign of the dividend.
- FIXUP: the result register is written and the next state is DONE.
- DONE: done=1, busy=0, next state IDLE. start in the DONE cycle is ignored.
- Special cases (divide ops only), resolved at acceptance:
  - Divisor 0: DIV/DIVU result all-ones; REM/REMU result = op_a.
  - Signed overflow (DIV/REM with op_a = 0x80..0 and op_b = all-ones): DIV result = op_a; REM result = 0.
- flush: takes effect from any state. Next state is IDLE, done is not pulsed, result is unchanged. flush and start in the same IDLE cycle: flush wins and nothing is accepted.
- rst_n=0 (including mid-operation): state IDLE, busy=0, done=0, result=0, counter=0.
- start while busy=1 is ignored. No queueing.

## Timing
- Cycle 0: start accepted in IDLE.
- Normal op: busy=1 in cycles 1..XLEN+1; done=1 and result valid in cycle XLEN+2 (34 for XLEN=32).
- Special case: busy stays 0; done=1 and result valid in cycle 1.
- Back-to-back: the earliest next acceptance is the cycle after done (IDLE).
- result changes only on the FIXUP→DONE or special-case transition.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- MUL 7 × 0xFFFFFFF9 (−7), XLEN=32 -> done at cycle 34, result 0xFFFFFFCF. busy high exactly cycles 1–33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD.
- REM −7 % 2 -> 0xFFFFFFFF.
- DIVU 100 / 7 -> 14.
- REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF at cycle 1.
- REMU 5 / 0 -> 5 at cycle 1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1.
- REM 0x80000000 / 0xFFFFFFFF -> 0 at cycle 1.
- Start DIVU 100/7, assert flush at cycle 10 -> busy=0 at cycle 11, no done pulse, result retains its prior value. A new MUL 3×4 accepted at cycle 12 -> 12 at cycle 46.
- Start MUL, drive rst_n=0 at cycle 5 -> from cycle 6: busy=0, done=0, result=0.
- Start held high throughout -> ops accepted at cycles 0 and 35 only; done pulses at cycles 34 and 69.
